// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the load/store info encodings used by execute, the stage FSM state
// type, the byte-enable constants for the data-memory port, and a helper that
// tells whether a load-info code names a real load.
package mem_pkg;

  // Load info encodings (6 and 7 are treated as "no load").
  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LH   = 3'd2;
  localparam logic [2:0] LOAD_LW   = 3'd3;
  localparam logic [2:0] LOAD_LBU  = 3'd4;
  localparam logic [2:0] LOAD_LHU  = 3'd5;

  // Store info encodings.
  localparam logic [1:0] STORE_NONE = 2'd0;
  localparam logic [1:0] STORE_SB   = 2'd1;
  localparam logic [1:0] STORE_SH   = 2'd2;
  localparam logic [1:0] STORE_SW   = 2'd3;

  // Byte-enable patterns for the data-memory port.
  localparam logic [3:0] WSTRB_NONE    = 4'b0000;
  localparam logic [3:0] WSTRB_BYTE0   = 4'b0001;
  localparam logic [3:0] WSTRB_HALF_LO = 4'b0011;
  localparam logic [3:0] WSTRB_HALF_HI = 4'b1100;
  localparam logic [3:0] WSTRB_WORD    = 4'b1111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  function automatic logic is_load_op(input logic [2:0] info);
    return (info != LOAD_NONE) && (info <= LOAD_LHU);
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// load_align: combinational load-data formatter.
// Selects the addressed byte or halfword from the raw memory word and
// sign- or zero-extends it according to the load type.
// Ports:
//   rdata     in  32  raw word returned by data memory
//   lane      in  2   low two address bits of the load
//   info_load in  3   load type (LOAD_* encoding)
//   data      out 32  extended value destined for rd
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  info_load,
  output logic [31:0] data
);

  logic [7:0]  lane_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_byte[gi] = rdata[8*gi +: 8];
  end

  always_comb begin
    sel_byte = lane_byte[lane];
    // Halfword loads are known aligned here, so only lane[1] matters.
    sel_half = lane[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (info_load)
      LOAD_LB:  data = {{24{sel_byte[7]}}, sel_byte};
      LOAD_LBU: data = {24'd0, sel_byte};
      LOAD_LH:  data = {{16{sel_half[15]}}, sel_half};
      LOAD_LHU: data = {16'd0, sel_half};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access stage of the RV32I pipeline.
// Accepts execute's bundle, runs loads/stores over a req/ready data-memory
// port, aligns store lanes and load data, and produces a registered
// write-back bundle with a one-cycle out_valid pulse per instruction.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   execute handshake (in_ready high only in IDLE)
//   alu_result, rs2E      ALU result / effective address, store data
//   write_regE, info_loadE, info_storeE, dstreg_addrE  instruction controls
//   dmem_req/we/addr/wstrb/wdata  data-memory request, held until dmem_ready
//   dmem_ready, dmem_rdata        data-memory completion and read word
//   out_valid, wb_data, wb_addr, wb_we  write-back bundle
//   misalign_err, bus_err           error pulses alongside out_valid
module mem_access
  import mem_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2E,
  input  logic        write_regE,
  input  logic [2:0]  info_loadE,
  input  logic [1:0]  info_storeE,
  input  logic [4:0]  dstreg_addrE,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_addr,
  output logic        wb_we,
  output logic        misalign_err,
  output logic        bus_err
);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       ld_type_reg;   // LOAD_NONE marks an outstanding store
  logic [1:0]       lane_reg;
  logic [4:0]       rd_reg;
  logic             wr_en_reg;
  logic [31:0]      addr_reg;

  logic        is_ld;
  logic        is_st;
  logic        is_half;
  logic        is_word;
  logic        misalign;
  logic        wr_en;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign in_ready = (state_reg == S_IDLE);

  // Decode the incoming bundle. A real load takes priority over any store.
  always_comb begin
    is_ld    = is_load_op(info_loadE);
    is_st    = !is_ld && (info_storeE != STORE_NONE);
    is_half  = is_ld ? ((info_loadE == LOAD_LH) || (info_loadE == LOAD_LHU))
                     : (is_st && (info_storeE == STORE_SH));
    is_word  = is_ld ? (info_loadE == LOAD_LW)
                     : (is_st && (info_storeE == STORE_SW));
    misalign = (is_half && alu_result[0]) || (is_word && (alu_result[1:0] != 2'b00));
    wr_en    = write_regE && (dstreg_addrE != 5'd0);
  end

  // Store lane placement: data is replicated so that the strobes alone pick
  // the bytes that land in memory.
  always_comb begin
    st_wstrb = WSTRB_NONE;
    st_wdata = rs2E;
    case (info_storeE)
      STORE_SB: begin
        st_wstrb = WSTRB_BYTE0 << alu_result[1:0];
        st_wdata = {4{rs2E[7:0]}};
      end
      STORE_SH: begin
        st_wstrb = alu_result[1] ? WSTRB_HALF_HI : WSTRB_HALF_LO;
        st_wdata = {2{rs2E[15:0]}};
      end
      STORE_SW: st_wstrb = WSTRB_WORD;
      default:  st_wstrb = WSTRB_NONE;
    endcase
  end

  // Formats the read word using the lane and type latched at acceptance.
  load_align u_load_align (
    .rdata     (dmem_rdata),
    .lane      (lane_reg),
    .info_load (ld_type_reg),
    .data      (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      ld_type_reg  <= LOAD_NONE;
      lane_reg     <= 2'd0;
      rd_reg       <= 5'd0;
      wr_en_reg    <= 1'b0;
      addr_reg     <= 32'd0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_wstrb   <= WSTRB_NONE;
      dmem_wdata   <= 32'd0;
      out_valid    <= 1'b0;
      wb_data      <= 32'd0;
      wb_addr      <= 5'd0;
      wb_we        <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      // Pulses default low; wb_* keep their last value.
      out_valid    <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            if (!is_ld && !is_st) begin
              out_valid <= 1'b1;
              wb_data   <= alu_result;
              wb_addr   <= dstreg_addrE;
              wb_we     <= wr_en;
            end else if (misalign) begin
              // Suppressed access: report it without touching the bus.
              out_valid    <= 1'b1;
              misalign_err <= 1'b1;
              wb_data      <= alu_result;
              wb_addr      <= dstreg_addrE;
              wb_we        <= 1'b0;
            end else begin
              state_reg   <= S_WAIT;
              cnt_reg     <= '0;
              dmem_req    <= 1'b1;
              dmem_we     <= is_st;
              dmem_addr   <= {alu_result[31:2], 2'b00};
              dmem_wstrb  <= is_st ? st_wstrb : WSTRB_NONE;
              dmem_wdata  <= is_st ? st_wdata : 32'd0;
              ld_type_reg <= is_ld ? info_loadE : LOAD_NONE;
              lane_reg    <= alu_result[1:0];
              rd_reg      <= dstreg_addrE;
              wr_en_reg   <= wr_en;
              addr_reg    <= alu_result;
            end
          end
        end

        S_WAIT: begin
          if (dmem_ready) begin
            state_reg <= S_IDLE;
            dmem_req  <= 1'b0;
            out_valid <= 1'b1;
            wb_addr   <= rd_reg;
            if (ld_type_reg != LOAD_NONE) begin
              wb_data <= ld_data;
              wb_we   <= wr_en_reg;
            end else begin
              wb_data <= addr_reg;
              wb_we   <= 1'b0;
            end
          end else if (cnt_reg == CNT_W'(WAIT_LIMIT - 1)) begin
            // Memory never answered: give up and flag a bus error.
            state_reg <= S_IDLE;
            dmem_req  <= 1'b0;
            out_valid <= 1'b1;
            bus_err   <= 1'b1;
            wb_data   <= addr_reg;
            wb_addr   <= rd_reg;
            wb_we     <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: the driver pushes expected write-back
// results and expected memory requests; a monitor and a memory responder pop
// and compare them as the DUT produces them.
module tb_mem_access;

  localparam int WAIT_LIMIT = 16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] rs2E;
  logic        write_regE;
  logic [2:0]  info_loadE;
  logic [1:0]  info_storeE;
  logic [4:0]  dstreg_addrE;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_we;
  logic        misalign_err;
  logic        bus_err;

  mem_access #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rs2E(rs2E), .write_regE(write_regE),
    .info_loadE(info_loadE), .info_storeE(info_storeE), .dstreg_addrE(dstreg_addrE),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .out_valid(out_valid), .wb_data(wb_data),
    .wb_addr(wb_addr), .wb_we(wb_we), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
    logic        mis;
    logic        bus;
    logic        chk_data;
    logic        chk_addr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        chk_wdata;
    int          delay;   // WAIT cycles before ready; negative = never
    int          ncyc;    // expected number of cycles dmem_req stays high
    logic [31:0] rdata;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ntx   = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Reference: pick the addressed bytes from the word and extend them.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0]        s;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    s = word >> (8 * off);
    b = s[7:0];
    h = s[15:0];
    case (op)
      3'd1: r = b;
      3'd2: r = h;
      3'd4: r = {24'd0, s[7:0]};
      3'd5: r = {16'd0, s[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  task automatic drive_junk(input logic v);
    in_valid     = v;
    alu_result   = $urandom;
    rs2E         = $urandom;
    write_regE   = 1'($urandom_range(0, 1));
    info_loadE   = 3'($urandom_range(0, 7));
    info_storeE  = 2'($urandom_range(0, 3));
    dstreg_addrE = 5'($urandom_range(0, 31));
  endtask

  // Present one instruction at the current negedge (stage must be ready) and
  // record what should come out of it.
  task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic wr,
                       input logic [2:0] ld, input logic [1:0] st, input logic [4:0] rd,
                       input int delay, input logic [31:0] rdata, input bit aborted);
    exp_t e;
    req_t r;
    int   size;
    bit   is_ld, is_st;
    logic [7:0] rb [4];
    in_valid = 1; alu_result = alu; rs2E = rs2; write_regE = wr;
    info_loadE = ld; info_storeE = st; dstreg_addrE = rd;
    is_ld = (ld >= 3'd1) && (ld <= 3'd5);
    is_st = !is_ld && (st != 2'd0);
    if (is_ld) size = (ld == 3'd3) ? 4 : ((ld == 3'd2 || ld == 3'd5) ? 2 : 1);
    else       size = (st == 2'd3) ? 4 : ((st == 2'd2) ? 2 : 1);
    e.cyc = cyc + 1; e.data = alu; e.addr = rd; e.we = 0; e.mis = 0; e.bus = 0;
    e.chk_data = 1; e.chk_addr = 0;
    if (!is_ld && !is_st) begin
      e.we = wr && (rd != 0);
      e.chk_addr = 1;
    end else if ((int'(alu[1:0]) % size) != 0) begin
      e.mis = 1;
    end else begin
      r.addr = alu & ~32'h3;
      r.we = is_st;
      r.chk_wdata = is_st;
      r.wstrb = is_st ? 4'(((1 << size) - 1) << alu[1:0]) : 4'b0000;
      rb[0] = rs2[7:0]; rb[1] = rs2[15:8]; rb[2] = rs2[23:16]; rb[3] = rs2[31:24];
      for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = rb[i % size];
      r.delay = delay;
      r.rdata = rdata;
      r.ncyc  = aborted ? 2 : ((delay < 0) ? WAIT_LIMIT : delay + 1);
      req_q.push_back(r);
      if (delay < 0) begin
        e.cyc = cyc + 1 + WAIT_LIMIT; e.bus = 1; e.chk_data = 0;
      end else begin
        e.cyc = cyc + 2 + delay;
        if (is_ld) begin
          e.data = ref_load(ld, alu[1:0], rdata);
          e.we = wr && (rd != 0);
          e.chk_addr = 1;
        end else begin
          e.chk_data = 0;
        end
      end
    end
    if (!aborted) exp_q.push_back(e);
  endtask

  // Advance to the next negedge where the stage can accept, driving ignored
  // junk (sometimes with in_valid high) while it is busy.
  task automatic next_slot();
    int guard = 0;
    @(negedge clk);
    while (!in_ready) begin
      drive_junk(1'($urandom_range(0, 1)));
      guard++;
      if (guard > 200) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        finish_run();
      end
      @(negedge clk);
    end
    drive_junk(1'b0);
  endtask

  // Write-back monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          ntx++;
          $display("txn %0d cyc=%0d wb_data=%h wb_addr=%0d wb_we=%b mis=%b bus=%b",
                   ntx, cyc, wb_data, wb_addr, wb_we, misalign_err, bus_err);
          chk("latency_cycle", 32'(cyc), 32'(e.cyc));
          chk("wb_we", 32'(wb_we), 32'(e.we));
          chk("misalign_err", 32'(misalign_err), 32'(e.mis));
          chk("bus_err", 32'(bus_err), 32'(e.bus));
          chk("in_ready_at_out", 32'(in_ready), 32'd1);
          if (e.chk_data) chk("wb_data", wb_data, e.data);
          if (e.chk_addr) chk("wb_addr", 32'(wb_addr), 32'(e.addr));
        end
      end
    end
  end

  // Data-memory responder: checks each request against the queue and answers
  // after the scheduled number of WAIT cycles. Ready/rdata are randomized while
  // no request is outstanding; the stage must ignore them.
  initial begin
    req_t cur;
    bit   prev = 0;
    int   n = 0;
    cur.addr = 0; cur.we = 0; cur.wstrb = 0; cur.wdata = 0; cur.chk_wdata = 0;
    cur.delay = -1; cur.ncyc = 0; cur.rdata = 0;
    dmem_ready = 0;
    dmem_rdata = 0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        if (!prev) begin
          n = 0;
          if (req_q.size() == 0) chk("unexpected_dmem_req", 32'(dmem_req), 32'd0);
          else cur = req_q.pop_front();
        end
        chk("dmem_addr", dmem_addr, cur.addr);
        chk("dmem_we", 32'(dmem_we), 32'(cur.we));
        chk("dmem_wstrb", 32'(dmem_wstrb), 32'(cur.wstrb));
        if (cur.chk_wdata) chk("dmem_wdata", dmem_wdata, cur.wdata);
        if (cur.delay >= 0 && n == cur.delay) begin
          dmem_ready = 1;
          dmem_rdata = cur.rdata;
        end else begin
          dmem_ready = 0;
          dmem_rdata = $urandom;
        end
        n++;
      end else begin
        if (prev) chk("req_held_cycles", 32'(n), 32'(cur.ncyc));
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
      prev = dmem_req;
    end
  end

  // Stimulus.
  initial begin
    int delay;
    rst = 1;
    drive_junk(1'b0);
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_dmem_req", 32'(dmem_req), 32'd0);
    chk("reset_dmem_addr", dmem_addr, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_wb_we", 32'(wb_we), 32'd0);
    chk("reset_errs", 32'({misalign_err, bus_err}), 32'd0);
    rst = 0;

    // Directed cases.
    issue(32'h0000_1234, 32'h0, 1, 3'd0, 2'd0, 5'd5, 0, 32'h0, 0); next_slot();
    issue(32'h0000_1234, 32'h0, 1, 3'd0, 2'd0, 5'd0, 0, 32'h0, 0); next_slot();
    issue(32'h0000_0103, 32'hAB, 1, 3'd0, 2'd1, 5'd3, 2, 32'h0, 0); next_slot();
    issue(32'h0000_0101, 32'h0, 1, 3'd1, 2'd0, 5'd6, 0, 32'h0000_F000, 0); next_slot();
    issue(32'h0000_0101, 32'h0, 1, 3'd4, 2'd0, 5'd6, 0, 32'h0000_F000, 0); next_slot();
    issue(32'h0000_0202, 32'h0, 1, 3'd3, 2'd0, 5'd8, 0, 32'h0, 0); next_slot();
    issue(32'h0000_0200, 32'h0, 1, 3'd3, 2'd0, 5'd9, -1, 32'h0, 0); next_slot();
    issue(32'h0000_0204, 32'h0, 1, 3'd3, 2'd3, 5'd10, 15, 32'hCAFE_F00D, 0); next_slot();
    issue(32'h0000_0306, 32'h1234_8765, 0, 3'd7, 2'd2, 5'd11, 1, 32'h0, 0); next_slot();

    // Reset during the second WAIT cycle abandons the access.
    issue(32'h0000_0300, 32'h0, 1, 3'd3, 2'd0, 5'd7, -1, 32'h0, 1);
    @(negedge clk); in_valid = 0;
    @(negedge clk); rst = 1;
    @(negedge clk);
    chk("rst_mid_wait_req", 32'(dmem_req), 32'd0);
    chk("rst_mid_wait_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_wait_in_ready", 32'(in_ready), 32'd1);
    rst = 0;
    issue(32'h0000_0002, 32'h0, 1, 3'd2, 2'd0, 5'd12, 0, 32'h8000_0000, 0); next_slot();

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) next_slot();
      delay = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 5);
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), delay, $urandom, 0);
      next_slot();
    end

    // Drain.
    for (int i = 0; i < 300 && (exp_q.size() != 0 || dmem_req); i++) @(negedge clk);
    chk("pending_writebacks", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    chk("pending_requests", 32'(req_q.size()), 32'd0);
    finish_run();
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, directly downstream of execute.
- Consumes execute's registered outputs: ALU result/address, store data, load/store info, write-back controls.
- Runs loads/stores over a req/ready data-memory port, aligns byte lanes, sign/zero-extends load data, and presents a registered write-back bundle.
- Stalls upstream via in_ready while a memory transaction is outstanding.

Parameters:
- WAIT_LIMIT, 16: max cycles dmem_req is held without dmem_ready before a bus error is declared.
- CNT_W, 5: width of the wait counter; must hold WAIT_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  execute bundle valid
- in_ready  out  1  stage can accept bundle this cycle
- alu_result  in  32  ALU result; effective address for ld/st
- rs2E  in  32  store data
- write_regE  in  1  instruction writes rd
- info_loadE  in  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU (6,7 = none)
- info_storeE  in  2  0 none, 1 SB, 2 SH, 3 SW
- dstreg_addrE  in  5  rd index
- dmem_req  out  1  memory request, held until dmem_ready
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address (low 2 bits zero)
- dmem_wstrb  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_ready  in  1  transaction complete; dmem_rdata valid this cycle
- dmem_rdata  in  32  raw read word
- out_valid  out  1  write-back bundle valid (one-cycle pulse per instruction)
- wb_data  out  32  value for rd
- wb_addr  out  5  rd index
- wb_we  out  1  register-file write enable
- misalign_err  out  1  pulse with out_valid: misaligned access suppressed
- bus_err  out  1  pulse with out_valid: wait timeout

Behaviour:
- Reset: state IDLE, counter 0; every output 0 except in_ready (1 in IDLE).
- Reset mid-WAIT: dmem_req drops at that edge; the transaction is abandoned and produces no out_valid.
- States: IDLE, WAIT. in_ready = (state==IDLE).
- IDLE, in_valid, no ld/st:
  - Next cycle out_valid=1, wb_data=alu_result, wb_addr=dstreg_addrE.
  - wb_we = write_regE && dstreg_addrE!=0.
  - Latency 1.
- Load and store both nonzero: load wins, store ignored.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No request issued.
  - Next cycle out_valid=1, wb_we=0, misalign_err=1, wb_data=alu_result.
- IDLE, aligned ld/st accepted:
  - Latch request regs; next cycle state=WAIT, dmem_req=1, counter=0.
  - dmem_addr = {addr[31:2],2'b00}.
  - SB: wstrb = 1<<addr[1:0], wdata = rs2[7:0] replicated to all 4 lanes.
  - SH: wstrb = 0011 or 1100, wdata = rs2[15:0] replicated to both halves.
  - SW: wstrb = 1111, wdata = rs2.
  - Loads: we=0, wstrb=0000.
- WAIT, each cycle:
  - dmem_ready=1:
    - dmem_req drops next cycle; state=IDLE next cycle.
    - Next cycle out_valid=1.
    - Load: wb_data = lane-selected byte/half from dmem_rdata, sign-extended (LB/LH) or zero-extended (LBU/LHU); wb_we per x0 rule.
    - Store: wb_we=0.
    - Minimum latency, accept to out_valid: 2 cycles.
  - else counter++. When counter reaches WAIT_LIMIT-1 without ready:
    - Drop req; state=IDLE.
    - out_valid=1, bus_err=1, wb_we=0 on the following cycle.
- dmem_req/addr/we/wstrb/wdata are stable while held in WAIT.
- dmem_ready sampled only in WAIT; ignored otherwise.
- New acceptance is possible in the same cycle out_valid is high, since state is IDLE by then.
- out_valid, misalign_err, bus_err are single-cycle pulses; wb_* hold their last value when out_valid=0.

Decomposition:
- Package mem_pkg holds:
  - LOAD_* / STORE_* encodings
  - state enum
  - WSTRB constants
- Sub-module load_align (combinational): rdata, addr[1:0], info_load -> extended 32-bit value. Keeps lane/extension logic separately testable.

Test Plan:
- alu_result=0x1234, write_regE=1, rd=5, no ld/st -> 1 cycle later out_valid=1, wb_data=0x1234, wb_we=1; with rd=0, wb_we=0.
- SB addr=0x103, rs2=0xAB -> dmem_addr=0x100, wstrb=1000, wdata=0xABABABAB; ready after 3 cycles -> req held 3 cycles, then out_valid with wb_we=0.
- LB addr=0x101, rdata=0x0000F000, ready immediately -> wb_data=0xFFFFFFF0. Same with LBU -> 0x000000F0.
- LW addr=0x202 -> no dmem_req, out_valid next cycle, misalign_err=1, wb_we=0.
- LW aligned, dmem_ready never asserted -> req high 16 cycles, then bus_err=1 with out_valid, wb_we=0, in_ready=1.
- rst asserted in 2nd WAIT cycle -> dmem_req=0 next cycle, no out_valid; a following LH addr=0x2, rdata=0x80000000 -> wb_data=0xFFFF8000.
